// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared encodings, stall/flush vector type and helper functions
//               for the 5-stage pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_M    = 2'b01;
  localparam logic [1:0] FWD_W    = 2'b10;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } pipe_ctrl_t;

  // Winning hazard cause for the current cycle, lowest to highest priority
  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_BR,
    CAUSE_LOAD,
    CAUSE_DIV,
    CAUSE_MEM,
    CAUSE_EXC
  } cause_e;

  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    return hit_m ? FWD_M : (hit_w ? FWD_W : FWD_NONE);
  endfunction

  function automatic pipe_ctrl_t ctrl_for(input cause_e cause);
    pipe_ctrl_t c;
    c = '0;
    case (cause)
      CAUSE_EXC: begin
        c.flush_d = 1'b1;
        c.flush_e = 1'b1;
        c.flush_m = 1'b1;
      end
      CAUSE_MEM: begin
        c.stall_f = 1'b1;
        c.stall_d = 1'b1;
        c.stall_e = 1'b1;
        c.stall_m = 1'b1;
        c.flush_w = 1'b1;
      end
      CAUSE_DIV, CAUSE_LOAD: begin
        c.stall_f = 1'b1;
        c.stall_d = 1'b1;
        c.stall_e = 1'b1;
        c.flush_m = 1'b1;
      end
      CAUSE_BR: begin
        c.stall_f = 1'b1;
        c.stall_d = 1'b1;
        c.flush_e = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Datapath <-> hazard controller signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rsD;
  logic [REG_AW-1:0] rtD;
  logic              branchD;
  logic [REG_AW-1:0] rsE;
  logic [REG_AW-1:0] rtE;
  logic              reg_write_enE;
  logic [REG_AW-1:0] reg_writeE;
  logic              reg_write_enM;
  logic [REG_AW-1:0] reg_writeM;
  logic              mem_read_enM;
  logic              reg_write_enW;
  logic [REG_AW-1:0] reg_writeW;
  logic              div_opE;
  logic              d_mem_stall;
  logic              flush_exc;

  logic              stallF;
  logic              stallD;
  logic              stallE;
  logic              stallM;
  logic              flushD;
  logic              flushE;
  logic              flushM;
  logic              flushW;
  logic [1:0]        forward_aE;
  logic [1:0]        forward_bE;
  logic              forward_aD;
  logic              forward_bD;
  logic              div_busy;

  // Datapath side
  modport master (
    output rsD, rtD, branchD, rsE, rtE, reg_write_enE, reg_writeE,
           reg_write_enM, reg_writeM, mem_read_enM, reg_write_enW, reg_writeW,
           div_opE, d_mem_stall, flush_exc,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
           forward_aE, forward_bE, forward_aD, forward_bD, div_busy
  );

  // Hazard controller side
  modport slave (
    input  rsD, rtD, branchD, rsE, rtE, reg_write_enE, reg_writeE,
           reg_write_enM, reg_writeM, mem_read_enM, reg_write_enW, reg_writeW,
           div_opE, d_mem_stall, flush_exc,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
           forward_aE, forward_bE, forward_aD, forward_bD, div_busy
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_div_stall_fsm.sv
// ============================================================================
// Module      : div_stall_fsm
// Description : Holds E for the multi-cycle divider, then gives one DONE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_stall_fsm
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic div_opE,
  input  logic abort,
  input  logic hold,
  output logic div_stall,
  output logic div_busy
);

  localparam int              CW       = $clog2(DIV_LAT + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(DIV_LAT - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          w_start;

  assign w_start = (r_state == DIV_IDLE) && div_opE;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (div_opE) begin
            r_state <= DIV_BUSY;
            r_cnt   <= CNT_INIT;
          end
        end
        // The divider keeps running while memory stalls the pipe
        DIV_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CNT_LAST) r_state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (!hold) r_state <= DIV_IDLE;
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  assign div_stall = w_start || (r_state == DIV_BUSY);
  // Busy covers the issue cycle as well, so a divide reports DIV_LAT+1 cycles
  assign div_busy  = (w_start && !abort && !rst) || (r_state != DIV_IDLE);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Forwarding selects and prioritised stall/flush for F/D/E/M/W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int DIV_LAT = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  logic       w_rsE_nz, w_rtE_nz, w_rsD_nz, w_rtD_nz;
  logic       w_load_use, w_br_stall, w_div_stall, w_div_busy;
  logic       w_br_e, w_br_m;
  cause_e     w_cause;
  pipe_ctrl_t w_ctrl;

  assign w_rsE_nz = (hz.rsE != ZERO_REG);
  assign w_rtE_nz = (hz.rtE != ZERO_REG);
  assign w_rsD_nz = (hz.rsD != ZERO_REG);
  assign w_rtD_nz = (hz.rtD != ZERO_REG);

  assign hz.forward_aE = fwd_sel(w_rsE_nz && hz.reg_write_enM && (hz.rsE == hz.reg_writeM),
                                 w_rsE_nz && hz.reg_write_enW && (hz.rsE == hz.reg_writeW));
  assign hz.forward_bE = fwd_sel(w_rtE_nz && hz.reg_write_enM && (hz.rtE == hz.reg_writeM),
                                 w_rtE_nz && hz.reg_write_enW && (hz.rtE == hz.reg_writeW));

  // A load result is not available in M, so the branch compare cannot take it
  assign hz.forward_aD = w_rsD_nz && hz.reg_write_enM && (hz.rsD == hz.reg_writeM) && !hz.mem_read_enM;
  assign hz.forward_bD = w_rtD_nz && hz.reg_write_enM && (hz.rtD == hz.reg_writeM) && !hz.mem_read_enM;

  assign w_load_use = hz.mem_read_enM && hz.reg_write_enM &&
                      ((w_rsE_nz && (hz.rsE == hz.reg_writeM)) ||
                       (w_rtE_nz && (hz.rtE == hz.reg_writeM)));

  assign w_br_e = hz.reg_write_enE && (hz.reg_writeE != ZERO_REG) &&
                  ((hz.rsD == hz.reg_writeE) || (hz.rtD == hz.reg_writeE));
  assign w_br_m = hz.mem_read_enM && (hz.reg_writeM != ZERO_REG) &&
                  ((hz.rsD == hz.reg_writeM) || (hz.rtD == hz.reg_writeM));
  assign w_br_stall = hz.branchD && (w_br_e || w_br_m);

  div_stall_fsm #(
    .DIV_LAT (DIV_LAT)
  ) u_div_fsm (
    .clk       (clk),
    .rst       (rst),
    .div_opE   (hz.div_opE),
    .abort     (hz.flush_exc),
    .hold      (hz.d_mem_stall),
    .div_stall (w_div_stall),
    .div_busy  (w_div_busy)
  );

  always_comb begin
    w_cause = CAUSE_NONE;
    if (rst)                  w_cause = CAUSE_NONE;
    else if (hz.flush_exc)    w_cause = CAUSE_EXC;
    else if (hz.d_mem_stall)  w_cause = CAUSE_MEM;
    else if (w_div_stall)     w_cause = CAUSE_DIV;
    else if (w_load_use)      w_cause = CAUSE_LOAD;
    else if (w_br_stall)      w_cause = CAUSE_BR;
  end

  assign w_ctrl = ctrl_for(w_cause);

  assign hz.stallF   = w_ctrl.stall_f;
  assign hz.stallD   = w_ctrl.stall_d;
  assign hz.stallE   = w_ctrl.stall_e;
  assign hz.stallM   = w_ctrl.stall_m;
  assign hz.flushD   = w_ctrl.flush_d;
  assign hz.flushE   = w_ctrl.flush_e;
  assign hz.flushM   = w_ctrl.flush_m;
  assign hz.flushW   = w_ctrl.flush_w;
  assign hz.div_busy = w_div_busy;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (DIV_LAT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  hazard_ctrl_if #(.REG_AW(5)) hz ();

  hazard_ctrl #(
    .REG_AW  (5),
    .DIV_LAT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  // {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW}
  logic [7:0] ctrl;
  assign ctrl = {hz.stallF, hz.stallD, hz.stallE, hz.stallM,
                 hz.flushD, hz.flushE, hz.flushM, hz.flushW};

  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_DIV  = 8'b1110_0010;
  localparam logic [7:0] C_MEM  = 8'b1111_0001;
  localparam logic [7:0] C_BR   = 8'b1100_0100;
  localparam logic [7:0] C_EXC  = 8'b0000_1110;

  task automatic clear_inputs();
    hz.rsD = '0; hz.rtD = '0; hz.branchD = 1'b0;
    hz.rsE = '0; hz.rtE = '0;
    hz.reg_write_enE = 1'b0; hz.reg_writeE = '0;
    hz.reg_write_enM = 1'b0; hz.reg_writeM = '0; hz.mem_read_enM = 1'b0;
    hz.reg_write_enW = 1'b0; hz.reg_writeW = '0;
    hz.div_opE = 1'b0; hz.d_mem_stall = 1'b0; hz.flush_exc = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    hz.div_opE = 1'b1;
    hz.d_mem_stall = 1'b1;
    cyc(); cyc(); #1;
    n_total++;
    if (ctrl !== C_NONE) $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_NONE);
    else n_pass++;
    cyc();
    clear_inputs();
    rst = 1'b0;
    #1;
    n_total++;
    if (hz.div_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", hz.div_busy);
    else n_pass++;
    n_total++;
    if (ctrl !== C_NONE) $display("FAIL post_reset_ctrl: got %b expected %b", ctrl, C_NONE);
    else n_pass++;
  endtask

  task automatic test_forward_e();
    cyc();
    clear_inputs();
    hz.reg_write_enM = 1'b1; hz.reg_writeM = 5'd3; hz.rsE = 5'd3; hz.rtE = 5'd7;
    #1;
    n_total++;
    if (hz.forward_aE !== 2'b01) $display("FAIL fwd_aE_M: got %b expected 01", hz.forward_aE);
    else n_pass++;
    n_total++;
    if (hz.forward_bE !== 2'b00) $display("FAIL fwd_bE_none: got %b expected 00", hz.forward_bE);
    else n_pass++;
    cyc();
    hz.reg_writeM = 5'd0; hz.rsE = 5'd0;
    #1;
    n_total++;
    if (hz.forward_aE !== 2'b00) $display("FAIL fwd_aE_zero: got %b expected 00", hz.forward_aE);
    else n_pass++;
    cyc();
    hz.reg_writeM = 5'd3; hz.rsE = 5'd3; hz.rtE = 5'd3;
    hz.reg_write_enW = 1'b1; hz.reg_writeW = 5'd3;
    #1;
    n_total++;
    if ({hz.forward_aE, hz.forward_bE} !== 4'b0101) $display("FAIL fwd_M_over_W: got %b expected 0101", {hz.forward_aE, hz.forward_bE});
    else n_pass++;
    cyc();
    hz.reg_write_enM = 1'b0;
    #1;
    n_total++;
    if ({hz.forward_aE, hz.forward_bE} !== 4'b1010) $display("FAIL fwd_W_only: got %b expected 1010", {hz.forward_aE, hz.forward_bE});
    else n_pass++;
    n_total++;
    if (ctrl !== C_NONE) $display("FAIL fwd_no_stall: got %b expected %b", ctrl, C_NONE);
    else n_pass++;
  endtask

  task automatic test_load_use();
    cyc();
    clear_inputs();
    hz.mem_read_enM = 1'b1; hz.reg_write_enM = 1'b1; hz.reg_writeM = 5'd4;
    hz.rsE = 5'd2; hz.rtE = 5'd4; hz.rsD = 5'd4;
    #1;
    n_total++;
    if (ctrl !== C_DIV) $display("FAIL load_use_ctrl: got %b expected %b", ctrl, C_DIV);
    else n_pass++;
    n_total++;
    if (hz.forward_aD !== 1'b0) $display("FAIL load_no_fwdD: got %b expected 0", hz.forward_aD);
    else n_pass++;
    cyc();
    hz.mem_read_enM = 1'b0; hz.reg_write_enM = 1'b0; hz.reg_writeM = 5'd0;
    hz.reg_write_enW = 1'b1; hz.reg_writeW = 5'd4;
    #1;
    n_total++;
    if (ctrl !== C_NONE) $display("FAIL load_use_release: got %b expected %b", ctrl, C_NONE);
    else n_pass++;
    n_total++;
    if (hz.forward_bE !== 2'b10) $display("FAIL load_fwd_bE_W: got %b expected 10", hz.forward_bE);
    else n_pass++;
  endtask

  task automatic test_branch();
    cyc();
    clear_inputs();
    hz.branchD = 1'b1; hz.rsD = 5'd5; hz.rtD = 5'd6;
    hz.reg_write_enE = 1'b1; hz.reg_writeE = 5'd5;
    #1;
    n_total++;
    if (ctrl !== C_BR) $display("FAIL br_stall_E: got %b expected %b", ctrl, C_BR);
    else n_pass++;
    cyc();
    hz.reg_write_enE = 1'b0; hz.reg_writeE = 5'd0;
    hz.reg_write_enM = 1'b1; hz.reg_writeM = 5'd5;
    #1;
    n_total++;
    if (ctrl !== C_NONE) $display("FAIL br_release: got %b expected %b", ctrl, C_NONE);
    else n_pass++;
    n_total++;
    if ({hz.forward_aD, hz.forward_bD} !== 2'b10) $display("FAIL br_fwdD: got %b expected 10", {hz.forward_aD, hz.forward_bD});
    else n_pass++;
    cyc();
    hz.mem_read_enM = 1'b1; hz.rtD = 5'd5; hz.rsD = 5'd1;
    #1;
    n_total++;
    if (ctrl !== C_BR) $display("FAIL br_stall_load_M: got %b expected %b", ctrl, C_BR);
    else n_pass++;
    n_total++;
    if (hz.forward_bD !== 1'b0) $display("FAIL br_load_no_fwdD: got %b expected 0", hz.forward_bD);
    else n_pass++;
  endtask

  task automatic test_div();
    cyc();
    clear_inputs();
    hz.div_opE = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin cyc(); #1; end
      n_total++;
      if ({ctrl, hz.div_busy} !== {C_DIV, 1'b1}) $display("FAIL div_stall_cyc%0d: got %b/%b expected %b/1", i, ctrl, hz.div_busy, C_DIV);
      else n_pass++;
    end
    cyc(); #1;
    n_total++;
    if ({ctrl, hz.div_busy} !== {C_NONE, 1'b1}) $display("FAIL div_done: got %b/%b expected %b/1", ctrl, hz.div_busy, C_NONE);
    else n_pass++;
    cyc();
    hz.div_opE = 1'b0;
    #1;
    n_total++;
    if ({ctrl, hz.div_busy} !== {C_NONE, 1'b0}) $display("FAIL div_idle: got %b/%b expected %b/0", ctrl, hz.div_busy, C_NONE);
    else n_pass++;
  endtask

  task automatic test_div_mem_stall();
    cyc();
    clear_inputs();
    hz.div_opE = 1'b1;
    #1;
    n_total++;
    if (ctrl !== C_DIV) $display("FAIL dms_start: got %b expected %b", ctrl, C_DIV);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      cyc();
      hz.d_mem_stall = 1'b1;
      #1;
      n_total++;
      if ({ctrl, hz.div_busy} !== {C_MEM, 1'b1}) $display("FAIL dms_mem%0d: got %b/%b expected %b/1", i, ctrl, hz.div_busy, C_MEM);
      else n_pass++;
    end
    cyc();
    hz.d_mem_stall = 1'b0;
    #1;
    n_total++;
    if (ctrl !== C_DIV) $display("FAIL dms_last_busy: got %b expected %b", ctrl, C_DIV);
    else n_pass++;
    cyc(); #1;
    n_total++;
    if ({ctrl, hz.div_busy} !== {C_NONE, 1'b1}) $display("FAIL dms_done: got %b/%b expected %b/1", ctrl, hz.div_busy, C_NONE);
    else n_pass++;
    cyc();
    hz.div_opE = 1'b0;
    #1;
    n_total++;
    if (hz.div_busy !== 1'b0) $display("FAIL dms_idle: got %b expected 0", hz.div_busy);
    else n_pass++;
  endtask

  task automatic test_abort();
    cyc();
    clear_inputs();
    hz.div_opE = 1'b1;
    cyc();
    hz.flush_exc = 1'b1;
    #1;
    n_total++;
    if ({ctrl, hz.div_busy} !== {C_EXC, 1'b1}) $display("FAIL exc_flush: got %b/%b expected %b/1", ctrl, hz.div_busy, C_EXC);
    else n_pass++;
    cyc();
    hz.flush_exc = 1'b0; hz.div_opE = 1'b0;
    #1;
    n_total++;
    if ({ctrl, hz.div_busy} !== {C_NONE, 1'b0}) $display("FAIL exc_abort: got %b/%b expected %b/0", ctrl, hz.div_busy, C_NONE);
    else n_pass++;
    // Reset in the middle of a division
    cyc();
    hz.div_opE = 1'b1;
    cyc();
    rst = 1'b1;
    #1;
    n_total++;
    if (ctrl !== C_NONE) $display("FAIL rst_mid_ctrl: got %b expected %b", ctrl, C_NONE);
    else n_pass++;
    cyc();
    rst = 1'b0; hz.div_opE = 1'b0;
    #1;
    n_total++;
    if ({ctrl, hz.div_busy} !== {C_NONE, 1'b0}) $display("FAIL rst_mid_abort: got %b/%b expected %b/0", ctrl, hz.div_busy, C_NONE);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      n_total++;
      if ({ctrl, hz.div_busy} !== {C_NONE, 1'b0}) $display("FAIL rst_no_done%0d: got %b/%b expected %b/0", i, ctrl, hz.div_busy, C_NONE);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_forward_e();
    test_load_use();
    test_branch();
    test_div();
    test_div_mem_stall();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
